// File: rtl/demux_one_to_4_stream_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one upstream valid/ready channel,
// four downstream valid/ready channels, and the destination select controls.
interface demux_one_to_4_stream_if #(
  parameter int unsigned W = 8
) ();
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         s0;
   logic         s1;
   logic         rr_en;
   logic [W-1:0] out0_data;
   logic [W-1:0] out1_data;
   logic [W-1:0] out2_data;
   logic [W-1:0] out3_data;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [1:0]   rr_ptr;

   modport master (
      output in_data, in_valid, s0, s1, rr_en, out_ready,
      input  in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, rr_ptr
   );

   modport slave (
      input  in_data, in_valid, s0, s1, rr_en, out_ready,
      output in_ready, out0_data, out1_data, out2_data, out3_data, out_valid, rr_ptr
   );
endinterface

// File: rtl/demux_one_to_4_stream.sv
// Registered 1-to-4 stream demultiplexer with a one-word holding register per output
// and an optional round-robin destination mode.
module demux_one_to_4_stream #(
   parameter int unsigned W = 8
) (
   input logic                     clk,
   input logic                     rst,
   demux_one_to_4_stream_if.slave  bus
);

   logic [W-1:0] data_q [4];
   logic [3:0]   vld_q;
   logic [3:0]   vld_d;
   logic [1:0]   rr_ptr_q;
   logic [1:0]   tgt;
   logic         in_ready;
   logic         accept;
   logic [3:0]   fill;

   always_comb begin
      tgt      = bus.rr_en ? rr_ptr_q : {bus.s0, bus.s1};
      in_ready = ~vld_q[tgt] | bus.out_ready[tgt];
      accept   = bus.in_valid & in_ready;
      fill     = accept ? (4'b0001 << tgt) : 4'b0000;
      // A fill wins over a same-cycle drain so the slot stays valid with the new word.
      vld_d    = fill | (vld_q & ~bus.out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q    <= 4'b0000;
         rr_ptr_q <= 2'd0;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int k = 0; k < 4; k++) begin
            if (fill[k]) begin
               data_q[k] <= bus.in_data;
            end
         end
         if (accept && bus.rr_en) begin
            rr_ptr_q <= rr_ptr_q + 2'd1;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out0_data = data_q[0];
   assign bus.out1_data = data_q[1];
   assign bus.out2_data = data_q[2];
   assign bus.out3_data = data_q[3];
   assign bus.out_valid = vld_q;
   assign bus.rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demux_one_to_4_stream.sv
// Directed bench for demux_one_to_4_stream: a vector table for the steady-state
// traffic plus hand-written reset sequences.
module tb_demux_one_to_4_stream;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   demux_one_to_4_stream_if #(.W(8)) bus ();

   demux_one_to_4_stream #(.W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       vld;
      logic [1:0] sel;
      logic       rr;
      logic [7:0] data;
      logic [3:0] ordy;
      logic       exp_rdy;
      logic [3:0] exp_ov;
      logic [1:0] exp_rr;
      int         ch;
      logic [7:0] exp_d;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] outd(input int ch);
      case (ch)
         0:       return bus.out0_data;
         1:       return bus.out1_data;
         2:       return bus.out2_data;
         default: return bus.out3_data;
      endcase
   endfunction

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, {28'd0, bus.out_valid}, 32'h0);
      chk({tag, "_rr_ptr"}, {30'd0, bus.rr_ptr}, 32'h0);
      chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'h1);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_data%0d", tag, k), {24'd0, outd(k)}, 32'h0);
      end
   endtask

   initial begin
      // Static select, one word per cycle
      vecs[0]  = '{1'b1, 2'b00, 1'b0, 8'h11, 4'b1111, 1'b1, 4'b0001, 2'd0, 0, 8'h11};
      vecs[1]  = '{1'b1, 2'b01, 1'b0, 8'h22, 4'b1111, 1'b1, 4'b0010, 2'd0, 1, 8'h22};
      vecs[2]  = '{1'b1, 2'b10, 1'b0, 8'h33, 4'b1111, 1'b1, 4'b0100, 2'd0, 2, 8'h33};
      vecs[3]  = '{1'b1, 2'b11, 1'b0, 8'h44, 4'b1111, 1'b1, 4'b1000, 2'd0, 3, 8'h44};
      vecs[4]  = '{1'b0, 2'b11, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 3, 8'h44};
      // Backpressure on ch2, then simultaneous drain and fill
      vecs[5]  = '{1'b1, 2'b10, 1'b0, 8'hA5, 4'b1011, 1'b1, 4'b0100, 2'd0, 2, 8'hA5};
      vecs[6]  = '{1'b1, 2'b10, 1'b0, 8'h5A, 4'b1011, 1'b0, 4'b0100, 2'd0, 2, 8'hA5};
      vecs[7]  = '{1'b1, 2'b10, 1'b0, 8'h5A, 4'b1111, 1'b1, 4'b0100, 2'd0, 2, 8'h5A};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 2, 8'h5A};
      // Parallel drain of ch1 with a fill of ch3
      vecs[9]  = '{1'b1, 2'b01, 1'b0, 8'h3C, 4'b1101, 1'b1, 4'b0010, 2'd0, 1, 8'h3C};
      vecs[10] = '{1'b1, 2'b11, 1'b0, 8'h7E, 4'b1111, 1'b1, 4'b1000, 2'd0, 3, 8'h7E};
      vecs[11] = '{1'b0, 2'b00, 1'b0, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd0, 3, 8'h7E};
      // Round-robin wrap with no downstream ready
      vecs[12] = '{1'b1, 2'b00, 1'b1, 8'h01, 4'b0000, 1'b1, 4'b0001, 2'd1, 0, 8'h01};
      vecs[13] = '{1'b1, 2'b00, 1'b1, 8'h02, 4'b0000, 1'b1, 4'b0011, 2'd2, 1, 8'h02};
      vecs[14] = '{1'b1, 2'b00, 1'b1, 8'h03, 4'b0000, 1'b1, 4'b0111, 2'd3, 2, 8'h03};
      vecs[15] = '{1'b1, 2'b00, 1'b1, 8'h04, 4'b0000, 1'b1, 4'b1111, 2'd0, 3, 8'h04};
      vecs[16] = '{1'b1, 2'b00, 1'b1, 8'h05, 4'b0000, 1'b0, 4'b1111, 2'd0, 0, 8'h01};
      vecs[17] = '{1'b1, 2'b00, 1'b1, 8'h05, 4'b0001, 1'b1, 4'b1111, 2'd1, 0, 8'h05};
      vecs[18] = '{1'b0, 2'b00, 1'b1, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd1, 0, 8'h05};
      // Mode switch: static word leaves rr_ptr alone, re-enable resumes at rr_ptr
      vecs[19] = '{1'b1, 2'b00, 1'b1, 8'h06, 4'b1111, 1'b1, 4'b0010, 2'd2, 1, 8'h06};
      vecs[20] = '{1'b1, 2'b00, 1'b0, 8'h07, 4'b1111, 1'b1, 4'b0001, 2'd2, 0, 8'h07};
      vecs[21] = '{1'b1, 2'b00, 1'b1, 8'h08, 4'b1111, 1'b1, 4'b0100, 2'd3, 2, 8'h08};
      vecs[22] = '{1'b0, 2'b00, 1'b1, 8'h00, 4'b1111, 1'b1, 4'b0000, 2'd3, 2, 8'h08};

      bus.in_data   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.s0        = 1'b0;
      bus.s1        = 1'b0;
      bus.rr_en     = 1'b0;
      bus.out_ready = 4'b0000;

      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_state("reset");

      for (int i = 0; i < 23; i++) begin
         bus.in_valid  = vecs[i].vld;
         {bus.s0, bus.s1} = vecs[i].sel;
         bus.rr_en     = vecs[i].rr;
         bus.in_data   = vecs[i].data;
         bus.out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].exp_rdy});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_out_valid", i), {28'd0, bus.out_valid}, {28'd0, vecs[i].exp_ov});
         chk($sformatf("v%0d_rr_ptr", i), {30'd0, bus.rr_ptr}, {30'd0, vecs[i].exp_rr});
         chk($sformatf("v%0d_out%0d_data", i, vecs[i].ch), {24'd0, outd(vecs[i].ch)},
             {24'd0, vecs[i].exp_d});
      end

      // Mid-traffic reset: park words in ch0 and ch2, then reset between edges
      bus.rr_en     = 1'b0;
      bus.out_ready = 4'b0000;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h9A;
      {bus.s0, bus.s1} = 2'b00;
      @(posedge clk);
      #1;
      bus.in_data   = 8'hBC;
      {bus.s0, bus.s1} = 2'b10;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      chk("mid_out_valid_before", {28'd0, bus.out_valid}, 32'h5);
      chk("mid_out2_data_before", {24'd0, bus.out2_data}, 32'hBC);
      #2 rst = 1'b1;
      #1;
      chk("mid_out_valid_async", {28'd0, bus.out_valid}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_state("after_mid_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
